// File: rtl/l1_cache_if.sv
// CPU-side and L2-side signal bundle for l1_cache; slave is the cache view, master the environment.
// Widths follow the cache parameters; keep the instance parameters in step with the cache.
interface l1_cache_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int BLOCK_SIZE = 16
);
   logic [ADDR_WIDTH-1:0]            cpu_addr;
   logic [DATA_WIDTH-1:0]            cpu_wdata;
   logic                             cpu_read;
   logic                             cpu_write;
   logic [DATA_WIDTH-1:0]            cpu_rdata;
   logic                             cpu_ready;
   logic                             cpu_hit;
   logic [ADDR_WIDTH-1:0]            l2_addr;
   logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_out;
   logic                             l2_read;
   logic                             l2_write;
   logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_in;
   logic                             l2_block_valid;
   logic                             l2_ready;

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_read, cpu_write,
      output cpu_rdata, cpu_ready, cpu_hit,
      output l2_addr, l2_data_out, l2_read, l2_write,
      input  l2_data_in, l2_block_valid, l2_ready
   );

   modport master (
      output cpu_addr, cpu_wdata, cpu_read, cpu_write,
      input  cpu_rdata, cpu_ready, cpu_hit,
      input  l2_addr, l2_data_out, l2_read, l2_write,
      output l2_data_in, l2_block_valid, l2_ready
   );
endinterface

// File: rtl/l1_cache.sv
// Direct-mapped write-through L1 with write-allocate; read hit completes 2 cycles after capture.
// One request at a time: inputs are ignored outside IDLE, and FETCH/WRITE_THRU stall until L2 answers.
module l1_cache #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int CACHE_SIZE = 256,
   parameter int BLOCK_SIZE = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   l1_cache_if.slave   bus,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
);
   localparam int NUM_LINES = CACHE_SIZE / BLOCK_SIZE;
   localparam int OFFSET_W  = $clog2(BLOCK_SIZE);
   localparam int INDEX_W   = $clog2(NUM_LINES);
   localparam int TAG_W     = ADDR_WIDTH - INDEX_W - OFFSET_W;

   typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] line_t;
   typedef enum logic [2:0] {IDLE, LOOKUP, FETCH, WRITE_THRU, RESP} state_t;

   state_t state, state_nxt;

   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  req_wr;

   logic [NUM_LINES-1:0]  valid;
   logic [TAG_W-1:0]      tag_arr  [NUM_LINES];
   line_t                 data_arr [NUM_LINES];

   logic [OFFSET_W-1:0]   req_off;
   logic [INDEX_W-1:0]    req_idx;
   logic [TAG_W-1:0]      req_tag;
   logic [ADDR_WIDTH-1:0] blk_addr;
   logic                  hit;
   logic                  l2_done;
   logic                  new_req;
   line_t                 fill_line;

   assign req_off  = req_addr[OFFSET_W-1:0];
   assign req_idx  = req_addr[OFFSET_W +: INDEX_W];
   assign req_tag  = req_addr[ADDR_WIDTH-1 -: TAG_W];
   assign blk_addr = {req_addr[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
   assign hit      = valid[req_idx] && (tag_arr[req_idx] == req_tag);
   assign l2_done  = bus.l2_ready && bus.l2_block_valid;
   assign new_req  = bus.cpu_read || bus.cpu_write;

   // Returned block with the store word merged in, so a write miss installs the updated line directly
   always_comb begin
      fill_line = bus.l2_data_in;
      if (req_wr) fill_line[req_off] = req_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      bus.cpu_ready   = 1'b0;
      bus.l2_read     = 1'b0;
      bus.l2_write    = 1'b0;
      bus.l2_addr     = '0;
      bus.l2_data_out = '0;
      case (state)
         IDLE:   if (new_req) state_nxt = LOOKUP;
         LOOKUP: begin
            if (!hit)        state_nxt = FETCH;
            else if (req_wr) state_nxt = WRITE_THRU;
            else             state_nxt = RESP;
         end
         FETCH: begin
            bus.l2_read = 1'b1;
            bus.l2_addr = blk_addr;
            if (l2_done) state_nxt = req_wr ? WRITE_THRU : RESP;
         end
         WRITE_THRU: begin
            bus.l2_write    = 1'b1;
            bus.l2_addr     = blk_addr;
            bus.l2_data_out = data_arr[req_idx];
            if (bus.l2_ready) state_nxt = RESP;
         end
         RESP: begin
            bus.cpu_ready = 1'b1;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_addr      <= '0;
         req_wdata     <= '0;
         req_wr        <= 1'b0;
         valid         <= '0;
         bus.cpu_rdata <= '0;
         bus.cpu_hit   <= 1'b0;
         hit_count     <= '0;
         miss_count    <= '0;
      end else begin
         case (state)
            IDLE: if (new_req) begin
               req_addr  <= bus.cpu_addr;
               req_wdata <= bus.cpu_wdata;
               req_wr    <= bus.cpu_write;
            end
            LOOKUP: begin
               bus.cpu_hit <= hit;
               if (hit) begin
                  if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                  if (!req_wr) bus.cpu_rdata <= data_arr[req_idx][req_off];
               end else if (miss_count != 16'hFFFF) begin
                  miss_count <= miss_count + 16'd1;
               end
            end
            FETCH: if (l2_done) begin
               valid[req_idx] <= 1'b1;
               if (!req_wr) bus.cpu_rdata <= fill_line[req_off];
            end
            default: ;
         endcase
      end
   end

   // Tag/data storage needs no reset: valid bits gate every use
   always_ff @(posedge clk) begin
      if (state == LOOKUP && hit && req_wr)
         data_arr[req_idx][req_off] <= req_wdata;
      if (state == FETCH && l2_done) begin
         tag_arr[req_idx]  <= req_tag;
         data_arr[req_idx] <= fill_line;
      end
   end
endmodule

// File: tb/tb_l1_cache.sv
// Directed plus randomized checks of l1_cache against a memory/residency model kept in the bench.
module tb_l1_cache;
   localparam int DW = 32, AW = 32, CS = 256, BS = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] hit_count, miss_count;
   int          ncmp = 0, nfail = 0;

   always #5 clk = ~clk;

   l1_cache_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) bus ();

   l1_cache #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CACHE_SIZE(CS), .BLOCK_SIZE(BS)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
   );

   // Model: backing memory contents plus which block each of the 16 lines holds
   logic [31:0] mem [logic [31:0]];
   bit          mv [16];
   logic [23:0] mt [16];
   int          exp_hits = 0, exp_misses = 0;

   `define CHK(n, o, e) chk(n, 512'(o), 512'(e))

   task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 32'h9E3779B1) ^ 32'h13572468;
   endfunction

   function automatic logic [511:0] mem_block(input logic [31:0] a);
      logic [511:0] b;
      for (int w = 0; w < 16; w++) b[w*32 +: 32] = mem_rd({a[31:4], 4'(w)});
      return b;
   endfunction

   task automatic idle_inputs();
      bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
      bus.l2_ready = 1'b0; bus.l2_block_valid = 1'b0;
   endtask

   task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input bit rd, input bit wr,
                         input int d, input int w);
      logic [3:0]   idx = a[7:4];
      logic [23:0]  tg = a[31:8];
      bit           exp_hit = mv[idx] && (mt[idx] == tg);
      int           exp_lat, fcnt = 0, wcnt = 0, lat = 0;
      bit           done = 0;
      logic [31:0]  exp_rdata = mem_rd(a);
      logic [511:0] exp_line = mem_block(a);
      exp_line[a[3:0]*32 +: 32] = wd;
      exp_lat = exp_hit ? (wr ? 3 + w : 2) : (wr ? 4 + d + w : 3 + d);
      if (exp_hit) exp_hits = (exp_hits == 65535) ? 65535 : exp_hits + 1;
      else         exp_misses = (exp_misses == 65535) ? 65535 : exp_misses + 1;

      @(negedge clk);
      bus.cpu_addr = a; bus.cpu_wdata = wd; bus.cpu_read = rd; bus.cpu_write = wr;
      for (int c = 1; c <= 200 && !done; c++) begin
         @(negedge clk);
         if (c == 1) begin
            // The captured request must not follow later input changes
            bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
            bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom;
         end
         bus.l2_ready = 1'b0; bus.l2_block_valid = 1'b0;
         `CHK("l2_exclusive", bus.l2_read & bus.l2_write, 1'b0);
         if (bus.l2_read) begin
            fcnt++;
            if (fcnt == 1) `CHK("fetch_addr", bus.l2_addr, {a[31:4], 4'h0});
            if (fcnt > d) begin
               bus.l2_ready = 1'b1; bus.l2_block_valid = 1'b1; bus.l2_data_in = mem_block(a);
            end
         end else if (bus.l2_write) begin
            wcnt++;
            if (wcnt == 1) begin
               `CHK("wt_addr", bus.l2_addr, {a[31:4], 4'h0});
               `CHK("wt_data", bus.l2_data_out, exp_line);
            end
            if (wcnt > w) bus.l2_ready = 1'b1;
         end else begin
            `CHK("l2_bus_idle_zero", {bus.l2_addr, bus.l2_data_out}, 0);
            bus.l2_ready = 1'($urandom); bus.l2_block_valid = 1'($urandom);
            bus.l2_data_in = {16{$urandom}};
         end
         if (bus.cpu_ready) begin lat = c; done = 1; end
      end
      `CHK("ready_seen", done, 1'b1);
      ncmp++;
      if (lat !== exp_lat) begin
         nfail++;
         $error("FAIL latency: observed %0d expected %0d", lat, exp_lat);
      end
      `CHK("fetch_seen", fcnt > 0, !exp_hit);
      `CHK("wt_seen", wcnt > 0, wr);
      ncmp++;
      if (bus.cpu_hit !== exp_hit) begin
         nfail++;
         $error("FAIL cpu_hit: observed %0h expected %0h", bus.cpu_hit, exp_hit);
      end
      if (!wr) `CHK("cpu_rdata", bus.cpu_rdata, exp_rdata);
      ncmp++;
      if (hit_count !== exp_hits[15:0]) begin
         nfail++;
         $error("FAIL hit_count: observed %0h expected %0h", hit_count, exp_hits[15:0]);
      end
      ncmp++;
      if (miss_count !== exp_misses[15:0]) begin
         nfail++;
         $error("FAIL miss_count: observed %0h expected %0h", miss_count, exp_misses[15:0]);
      end
      @(negedge clk);
      idle_inputs();
      `CHK("ready_single_pulse", bus.cpu_ready, 1'b0);
      `CHK("hit_hold", bus.cpu_hit, exp_hit);
      mv[idx] = 1; mt[idx] = tg;
      if (wr) mem[a] = wd;
   endtask

   task automatic check_all_zero(input string name);
      `CHK(name, {bus.cpu_rdata, bus.cpu_ready, bus.cpu_hit, bus.l2_read, bus.l2_write,
                  bus.l2_addr, hit_count, miss_count}, 0);
      `CHK({name, "_l2data"}, bus.l2_data_out, 0);
   endtask

   initial begin
      bit          seen;
      logic [31:0] a, wd;
      int          op;
      idle_inputs();
      bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.l2_data_in = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset_state");
      rst_n = 1'b1;

      mem[32'h123] = 32'hDEADBEEF;
      do_req(32'h123, 0, 1, 0, 3, 0);
      ncmp++;
      if (bus.cpu_rdata !== 32'hDEADBEEF) begin
         nfail++;
         $error("FAIL cold_read_data: observed %0h expected %0h", bus.cpu_rdata, 32'hDEADBEEF);
      end
      do_req(32'h123, 0, 1, 0, 0, 0);
      do_req(32'h125, 32'hCAFEF00D, 0, 1, 0, 2);
      do_req(32'h125, 0, 1, 0, 0, 0);
      ncmp++;
      if (bus.cpu_rdata !== 32'hCAFEF00D) begin
         nfail++;
         $error("FAIL write_then_read: observed %0h expected %0h", bus.cpu_rdata, 32'hCAFEF00D);
      end
      do_req(32'h223, 0, 1, 0, 1, 0);
      do_req(32'h123, 0, 1, 0, 2, 0);
      ncmp++;
      if (miss_count !== 16'd3) begin
         nfail++;
         $error("FAIL conflict_miss_count: observed %0d expected %0d", miss_count, 3);
      end

      // Reset in the middle of a fetch, then a late L2 response
      @(negedge clk);
      bus.cpu_addr = 32'h300; bus.cpu_read = 1'b1;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         bus.cpu_read = 1'b0;
         seen = bus.l2_read;
      end
      `CHK("abort_fetch_reached", seen, 1'b1);
      rst_n = 1'b0;
      #1 check_all_zero("abort_reset");
      @(negedge clk);
      bus.l2_ready = 1'b1; bus.l2_block_valid = 1'b1; bus.l2_data_in = mem_block(32'h300);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         ncmp++;
         if ({bus.cpu_ready, bus.l2_read, bus.l2_write} !== 3'b000) begin
            nfail++;
            $error("FAIL late_l2_ignored: observed %0b expected %0b",
                   {bus.cpu_ready, bus.l2_read, bus.l2_write}, 3'b000);
         end
      end
      idle_inputs();
      for (int i = 0; i < 16; i++) mv[i] = 0;
      exp_hits = 0; exp_misses = 0;
      do_req(32'h123, 0, 1, 0, 1, 0);

      // Read and write together on a cold line is a write miss
      do_req(32'h4567, 32'h0BADF00D, 1, 1, 1, 1);
      do_req(32'h4567, 0, 1, 0, 0, 0);

      for (int n = 0; n < 80; n++) begin
         a  = {22'h0, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom)};
         wd = $urandom;
         op = $urandom_range(0, 2);
         do_req(a, wd, op != 1, op != 0, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/l1_cache.md
L1_CACHE -- requirements
Module: l1_cache

Interface
REQ-001 Parameters SHALL be exactly as listed, one per line: name, default, meaning.
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 32, word address width.
- CACHE_SIZE, 256, capacity in words.
- BLOCK_SIZE, 16, words per line.
REQ-002 Derived values SHALL be:
- NUM_LINES = CACHE_SIZE/BLOCK_SIZE.
- OFFSET_W = clog2(BLOCK_SIZE).
- INDEX_W = clog2(NUM_LINES).
- TAG_W = ADDR_WIDTH-INDEX_W-OFFSET_W.
REQ-003 Ports SHALL be exactly as listed, one per line: name direction width meaning.
- clk in 1 clock, rising edge.
- rst_n in 1 reset, asynchronous, active-low.
- cpu_addr in ADDR_WIDTH word address.
- cpu_wdata in DATA_WIDTH store data.
- cpu_read in 1 load request.
- cpu_write in 1 store request.
- cpu_rdata out DATA_WIDTH load data.
- cpu_ready out 1 one-cycle completion pulse.
- cpu_hit out 1 hit flag, valid with cpu_ready.
- l2_addr out ADDR_WIDTH block-aligned address.
- l2_data_out out BLOCK_SIZE*DATA_WIDTH write-through block.
- l2_read out 1 block fetch request.
- l2_write out 1 block write request.
- l2_data_in in BLOCK_SIZE*DATA_WIDTH returned block.
- l2_block_valid in 1 l2_data_in valid.
- l2_ready in 1 L2 completion.
- hit_count out 16 saturating hit counter.
- miss_count out 16 saturating miss counter.

Function
REQ-004 The cache SHALL be direct-mapped with NUM_LINES lines, each holding a valid bit, a TAG_W tag and BLOCK_SIZE words.
REQ-005 Address fields SHALL be offset=cpu_addr[OFFSET_W-1:0], index=next INDEX_W bits, tag=remaining upper bits.
REQ-006 The FSM SHALL have states IDLE, LOOKUP, FETCH, WRITE_THRU, RESP.
REQ-007 IDLE: on cpu_read|cpu_write at a rising edge, the block SHALL capture addr, wdata and op into registers and go to LOOKUP; later input changes SHALL be ignored until the next IDLE.
REQ-008 With cpu_read and cpu_write both high, the request SHALL be treated as a write.
REQ-009 LOOKUP, read hit: the block SHALL load cpu_rdata with the addressed word, set cpu_hit=1, increment hit_count, and go to RESP.
REQ-010 LOOKUP, write hit: the block SHALL merge wdata into the line, set cpu_hit=1, increment hit_count, and go to WRITE_THRU.
REQ-011 LOOKUP, miss: the block SHALL set cpu_hit=0, increment miss_count, and go to FETCH.
REQ-012 FETCH: l2_read=1 and l2_addr={tag,index,0} SHALL be held until l2_ready&&l2_block_valid is sampled at an edge. At that edge the block SHALL:
- install l2_data_in, set valid and write the tag, unconditionally overwriting the line;
- on a read, load cpu_rdata from the installed block and go to RESP;
- on a write, merge wdata into the installed line and go to WRITE_THRU.
REQ-013 WRITE_THRU: l2_write=1, l2_addr block-aligned and l2_data_out = full updated line SHALL be held until l2_ready is sampled; the block SHALL then go to RESP.
REQ-014 RESP: cpu_ready=1 for exactly one cycle, then the block SHALL return to IDLE. cpu_rdata and cpu_hit SHALL hold until the next LOOKUP.
REQ-015 l2_read and l2_write SHALL never be high together. Both SHALL be 0 outside FETCH and WRITE_THRU; l2_addr and l2_data_out SHALL be 0 there.
REQ-016 l2_ready or l2_block_valid arriving outside FETCH/WRITE_THRU SHALL be ignored.
REQ-017 Hit read latency SHALL be cpu_ready high in the 2nd cycle after the sampling edge.
REQ-018 Miss latency SHALL be L2 wait cycles + 2, plus write-through wait cycles when the request is a write.
REQ-019 hit_count and miss_count SHALL saturate at 16'hFFFF.
REQ-020 A request still asserted in IDLE after cpu_ready SHALL be accepted as a new request; the CPU deasserts in the cpu_ready cycle.

Reset
REQ-021 On rst_n low, asynchronously, the block SHALL force:
- state to IDLE;
- all valid bits to 0;
- cpu_ready, cpu_hit, cpu_rdata, l2_read, l2_write, l2_addr, l2_data_out, hit_count and miss_count to 0.
Tag and data arrays need no reset.
REQ-022 Reset during FETCH or WRITE_THRU SHALL abort the transaction with no line installed. L2 responses arriving after reset release SHALL be ignored per REQ-016.

Verification
REQ-023 Cold read 0x0000_0123, L2 ready 3 cycles later with word3=0xDEADBEEF:
- during FETCH: l2_read=1, l2_addr=0x120;
- at completion: cpu_rdata=0xDEADBEEF, cpu_hit=0, miss_count=1.
REQ-024 Repeat read 0x123: cpu_ready 2 cycles after sampling, cpu_hit=1, hit_count=1, l2_read never asserted.
REQ-025 Write 0xCAFEF00D to 0x125 (line resident): l2_write=1 with word5=0xCAFEF00D in l2_data_out; a subsequent read of 0x125 returns 0xCAFEF00D as a hit.
REQ-026 Conflict: read 0x123, then read 0x223 (same index 2, different tag).
- the second read misses;
- a third read of 0x123 misses again;
- miss_count=3.
REQ-027 Assert rst_n low mid-FETCH of 0x300:
- after reset all outputs are 0;
- a late l2_ready is ignored;
- a read of 0x123 misses.
REQ-028 cpu_read=cpu_write=1 on a cold address: FETCH then WRITE_THRU occur, and cpu_ready pulses exactly once.
